// File: rtl/sseg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus: settles each strobed digit,
// decodes glyph + dp, reassembles 4-digit frames. Optional frame confirmation via SSEG_CONFIRM_EN.
module sseg_scan_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        digit_err,
    output logic [3:0]  seen
);
    localparam logic [7:0] SETTLE_W = 8'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_SETTLING, S_CAPTURED} state_t;

    state_t      state_q, state_d;
    logic [11:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  fdp_q, fdp_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  dp_q, dp_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
`ifdef SSEG_CONFIRM_EN
    logic [19:0] cand_q, cand_d;
    logic        cand_vld_q, cand_vld_d;
`endif

    logic [11:0] cur;
    logic        strobe_ok;
    logic [1:0]  idx;
    logic        legal;
    logic [3:0]  nib;
    logic        capture;

    always_comb begin
        cur       = {an, sseg};
        strobe_ok = 1'b1;
        idx       = 2'd0;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: strobe_ok = 1'b0;
        endcase

        legal = 1'b1;
        nib   = 4'h0;
        case (sseg[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        prev_d  = cur;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        fdp_d   = fdp_q;
        seen_d  = seen_q;
        value_d = value_q;
        dp_d    = dp_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
`ifdef SSEG_CONFIRM_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
`endif

        // A dwell continues only while the strobe stays valid and nothing changed;
        // anything else starts a fresh count at 1.
        if (!strobe_ok) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else if (state_q != S_IDLE && cur == prev_q) begin
            if (state_q == S_SETTLING) begin
                cnt_d = 8'(cnt_q + 8'd1);
            end
        end else begin
            state_d = S_SETTLING;
            cnt_d   = 8'd1;
        end

        if (strobe_ok && state_d == S_SETTLING && cnt_d == SETTLE_W) begin
            capture = 1'b1;
            state_d = S_CAPTURED;
        end

        if (capture) begin
            if (legal) begin
                frame_d[{idx, 2'b00} +: 4] = nib;
                fdp_d[idx]                 = ~sseg[7];
                seen_d[idx]                = 1'b1;
                if (seen_d == 4'hF) begin
                    seen_d = 4'h0;
`ifdef SSEG_CONFIRM_EN
                    if (cand_vld_q && cand_q == {frame_d, fdp_d}) begin
                        value_d = frame_d;
                        dp_d    = fdp_d;
                        fv_d    = 1'b1;
                    end
                    cand_d     = {frame_d, fdp_d};
                    cand_vld_d = 1'b1;
`else
                    value_d = frame_d;
                    dp_d    = fdp_d;
                    fv_d    = 1'b1;
`endif
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            fdp_q   <= '0;
            seen_q  <= '0;
            value_q <= '0;
            dp_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef SSEG_CONFIRM_EN
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            fdp_q   <= fdp_d;
            seen_q  <= seen_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
`ifdef SSEG_CONFIRM_EN
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign digit_err   = err_q;
    assign seen        = seen_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: run-length behavioural model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sseg_scan_decoder;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [7:0]  sseg = 8'hFF;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        frame_valid, digit_err;
    logic [3:0]  seen;

    int checks = 0;
    int failures = 0;

    sseg_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .an(an), .sseg(sseg),
        .value(value), .dp(dp), .frame_valid(frame_valid),
        .digit_err(digit_err), .seen(seen)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_val, m_wval;
    logic [3:0]  m_dp, m_wdp, m_seen;
    logic        m_fv, m_err;
    int          run;
    logic [11:0] last;
    logic [19:0] m_cand;
    logic        m_cand_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val = 0; m_dp = 0; m_fv = 0; m_err = 0; m_seen = 0;
            m_wval = 0; m_wdp = 0; run = 0; last = 0; m_cand = 0; m_cand_v = 0;
        end else begin
            int d, g;
            m_fv = 0; m_err = 0;
            if ($countones(~an) == 1) run = (run > 0 && {an, sseg} == last) ? run + 1 : 1;
            else run = 0;
            last = {an, sseg};
            if (run == SETTLE) begin
                d = 0; g = -1;
                for (int k = 0; k < 4; k++) if (!an[k]) d = k;
                for (int k = 0; k < 16; k++) if (glyph[k] == sseg[6:0]) g = k;
                if (g < 0) m_err = 1;
                else begin
                    m_wval[d*4 +: 4] = g[3:0];
                    m_wdp[d] = ~sseg[7];
                    m_seen[d] = 1;
                    if (m_seen == 4'hF) begin
                        m_seen = 0;
`ifdef SSEG_CONFIRM_EN
                        if (m_cand_v && m_cand == {m_wval, m_wdp}) begin
                            m_val = m_wval; m_dp = m_wdp; m_fv = 1;
                        end
                        m_cand = {m_wval, m_wdp}; m_cand_v = 1;
`else
                        m_val = m_wval; m_dp = m_wdp; m_fv = 1;
`endif
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("value", 32'(value), 32'(m_val));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("digit_err", 32'(digit_err), 32'(m_err));
        chk("seen", 32'(seen), 32'(m_seen));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a; sseg = s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame(input logic [7:0] s0, s1, s2, s3);
        step(4'b1110, s0, 6);
        step(4'b1101, s1, 6);
        step(4'b1011, s2, 6);
        step(4'b0111, s3, 4);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_value", 32'(value), 0);
        chk("reset_seen", 32'(seen), 0);
        rst = 1'b0;

        // short dwell, then a full one
        step(4'b1110, 8'hF9, 3);
        step(4'b1111, 8'hF9, 1);
        chk("short_dwell_seen", 32'(seen), 0);
        step(4'b1110, 8'hF9, 3);
        chk("dwell3_seen", 32'(seen), 0);
        step(4'b1110, 8'hF9, 1);
        chk("dwell4_seen", 32'(seen), 4'b0001);

        // async reset mid-dwell with seen=0011
        step(4'b1101, 8'hA4, 4);
        chk("pre_reset_seen", 32'(seen), 4'b0011);
        step(4'b1011, 8'hB0, 2);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_seen", 32'(seen), 0);
        chk("async_reset_fv", 32'(frame_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(4'b1011, 8'hB0, 3);
        chk("post_reset_3", 32'(seen), 0);
        step(4'b1011, 8'hB0, 1);
        chk("post_reset_4", 32'(seen), 4'b0100);

        // full frame 4321
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
`ifdef SSEG_CONFIRM_EN
        chk("frame1_fv", 32'(frame_valid), 0);
        chk("frame1_value", 32'(value), 0);
`else
        chk("frame1_fv", 32'(frame_valid), 1);
        chk("frame1_value", 32'(value), 16'h4321);
        chk("frame1_dp", 32'(dp), 0);
`endif
        chk("frame1_seen", 32'(seen), 0);
        step(4'b0111, 8'h99, 2);
        chk("frame1_fv_drop", 32'(frame_valid), 0);

        // illegal glyph
        step(4'b1110, 8'hFF, 4);
        chk("illegal_err", 32'(digit_err), 1);
        step(4'b1110, 8'hFF, 4);
        chk("illegal_seen", 32'(seen), 0);

        // idle strobes
        step(4'b1100, 8'hF9, 10);
        step(4'b1111, 8'hF9, 10);
        chk("idle_seen", 32'(seen), 0);

        // overwrite digit 2 and decimal point
        step(4'b1011, 8'h99, 6);
        step(4'b1011, 8'h40, 6);
        step(4'b1110, 8'hF9, 6);
        step(4'b1101, 8'hF9, 6);
        step(4'b0111, 8'hF9, 4);
`ifdef SSEG_CONFIRM_EN
        chk("dp_fv", 32'(frame_valid), 0);
`else
        chk("dp_value", 32'(value), 16'h1011);
        chk("dp_dp", 32'(dp), 4'b0100);
`endif
        step(4'b1111, 8'hFF, 2);

        // repeated frames, then a differing one
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        step(4'b1111, 8'hFF, 2);
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("repeat_fv", 32'(frame_valid), 1);
        chk("repeat_value", 32'(value), 16'h4321);
        step(4'b1111, 8'hFF, 2);
        frame(8'hA4, 8'hA4, 8'hB0, 8'h99);
`ifdef SSEG_CONFIRM_EN
        chk("differ_fv", 32'(frame_valid), 0);
        chk("differ_value", 32'(value), 16'h4321);
`else
        chk("differ_fv", 32'(frame_valid), 1);
        chk("differ_value", 32'(value), 16'h4322);
`endif
        step(4'b1111, 8'hFF, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side monitor for the multiplexed seven-segment display bus. It watches the active-low anode strobes and segment lines produced by the display multiplexer and decodes each strobed glyph back to its hex nibble and decimal point. It reassembles full four-digit frames and publishes the 16-bit value with a one-cycle strobe. It is used as a loopback checker and self-test observer beside the display driver, in the same clock domain.

## Interface

Parameters:

- `SETTLE`, default 4: consecutive identical samples of {an, sseg} required before a digit is captured. Legal range 1..255.

Ports:

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `an`  in  4  anode strobes, active-low. `an[i]==0` selects digit i; digit 0 is the rightmost, `value[3:0]`.
- `sseg`  in  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `value`  out  16  last published frame; digit i occupies `value[4i+3:4i]`.
- `dp`  out  4  last published decimal points; 1 means lit.
- `frame_valid`  out  1  one-cycle pulse when `value`/`dp` update.
- `digit_err`  out  1  one-cycle pulse when a settled glyph is not a legal hex pattern.
- `seen`  out  4  digits captured since the last completed frame.

## Operation

- Sample valid only when `an` has exactly one zero bit: 1110, 1101, 1011 or 0111. Any other `an` value is idle; it clears the stability counter and the dwell-captured flag.
- Stability counter counts edges on which {an, sseg} equals the previous edge's value. Any change restarts the count at 1.
- Capture occurs once per dwell, on the edge where the count reaches `SETTLE`. A longer dwell does not recapture. A new dwell of the same digit recaptures, and the latest capture wins.
- Glyph decode uses `sseg[6:0]`, active-low: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
- `dp` bit for the digit = `~sseg[7]`.
- Legal glyph: store the nibble and dp into the working frame and set `seen[i]`.
- Illegal glyph: pulse `digit_err`. The digit is not stored and `seen` is unchanged.
- Frame completion: a capture that makes `seen==4'b1111` completes the frame.
  - The working frame, including the digit just captured, goes to publish logic.
  - `seen` clears on the same edge.
- State machine, per dwell: IDLE (no valid strobe) → SETTLING (count < SETTLE) → CAPTURED (holds until {an, sseg} changes) → SETTLING or IDLE.

## Timing

- Reset values: `value`=0, `dp`=0, `frame_valid`=0, `digit_err`=0, `seen`=0. The working frame, counter, FSM state (IDLE) and confirm buffer are also cleared.
- Capture latency: outputs update on the `SETTLE`-th consecutive rising edge that samples an unchanged valid {an, sseg}, i.e. the capture edge.
- On the capture edge that completes a frame, the following all take effect together:
  - `value` and `dp` update;
  - `frame_valid` pulses high for exactly that cycle;
  - `seen` returns to 0.
- `digit_err` is high for exactly the capture-edge cycle.
- Back-to-back frames may publish every 4×`SETTLE` cycles; no idle gap is required.
- Reset asserted mid-dwell or mid-frame discards all partial state immediately. The first post-reset capture needs a full `SETTLE` dwell.

## Configuration

- `SSEG_CONFIRM_EN` defined:
  - A completed frame is held in a candidate register.
  - The frame publishes (`value`/`dp` update, `frame_valid` pulse) only if it equals the previous completed frame, both 16-bit value and 4-bit dp.
  - A mismatch replaces the candidate silently.
  - The first completed frame after reset never publishes.
- `SSEG_CONFIRM_EN` undefined: every completed frame publishes immediately and no candidate register exists.

## Test plan

- Reset: assert `rst` asynchronously mid-dwell, with `seen`=0011 → all outputs 0 immediately. After release, the next capture requires 4 full stable cycles (`SETTLE`=4).
- Full frame, confirm macro undefined: drive an=1110/F9, 1101/A4, 1011/B0, 0111/99, 6 cycles each → a single `frame_valid` pulse on the 4th stable edge of digit 3. Result: `value`=16'h4321, `dp`=0, `seen` back to 0.
- Short dwell: an=1110/F9 for 3 cycles, then an=1111 → no capture and `seen`=0. The same glyph held 4 cycles → `seen`=0001 exactly on the 4th edge.
- Illegal glyph and idle strobes: an=1110 with sseg=FF held 8 cycles → exactly one `digit_err` pulse and `seen[0]` stays 0. an=1100 or 1111 for 10 cycles → no capture and no error.
- Decimal point and overwrite: digit 2 first captured as 99, then recaptured as 40; complete the frame with digits 0, 1 and 3 as F9 → `value`=16'h1011 (digit 2 = 0), `dp`=4'b0100.
- `SSEG_CONFIRM_EN` defined:
  - Frame 16'h4321 twice → no pulse after the first frame; pulse after the second.
  - Then frame 16'h4322 once → no publish, and `value` stays 16'h4321.
